// File: rtl/vector_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vector_mem_ctrl
// Purpose  : Serialises a three-lane GPU vector access onto a single-port
//            data RAM, stalling the GPU until the access completes.
// Revision : 1.0  initial release
// ============================================================================
module vector_mem_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 18,
    parameter int LANES  = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          MemReq,
    input  logic                          MemWrite,
    input  logic [ADDR_W-1:0]             A1,
    input  logic [ADDR_W-1:0]             A2,
    input  logic [ADDR_W-1:0]             A3,
    input  logic [LANES-1:0][DATA_W-1:0]  writeData,
    output logic [LANES-1:0][DATA_W-1:0]  ReadData,
    output logic                          Stall,
    output logic                          Done,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic                          ram_we,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata
);

    localparam int K_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [K_W-1:0] c_LAST_LANE = K_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_LAST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [K_W-1:0]                 r_k;
    logic [ADDR_W-1:0]              r_addr [LANES];
    logic [LANES-1:0][DATA_W-1:0]   r_wdata;
    logic                           r_is_write;
    logic                           r_cap_valid;
    logic [K_W-1:0]                 r_cap_lane;
    logic [LANES-1:0][DATA_W-1:0]   r_read_data;
    logic [ADDR_W-1:0]              w_addr_in [LANES];
    logic                           w_accept;
    logic                           w_acc_write;

    assign w_addr_in[0] = A1;
    assign w_addr_in[1] = A2;
    assign w_addr_in[2] = A3;

    assign w_accept    = (r_state == S_IDLE) && MemReq;
    assign w_acc_write = (r_state == S_ACC) && r_is_write;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        Stall       = 1'b0;
        Done        = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                if (MemReq) begin
                    w_state_nxt = S_ACC;
                    Stall       = 1'b1;
                end
            end
            S_ACC: begin
                Stall    = 1'b1;
                ram_addr = r_addr[r_k];
                if (r_is_write) begin
                    ram_wdata = r_wdata[r_k];
                end
                if (r_k == c_LAST_LANE) begin
                    w_state_nxt = r_is_write ? S_DONE : S_LAST;
                end
            end
            S_LAST: begin
                Stall       = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                Done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A write is suppressed in the reset cycle itself so a partial access stops cleanly.
    assign ram_we = w_acc_write && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_k        <= '0;
            r_is_write <= 1'b0;
            r_wdata    <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_addr[i] <= '0;
            end
        end else if (w_accept) begin
            r_k        <= '0;
            r_is_write <= MemWrite;
            r_wdata    <= writeData;
            for (int i = 0; i < LANES; i++) begin
                r_addr[i] <= w_addr_in[i];
            end
        end else if (r_state == S_ACC) begin
            r_k <= r_k + 1'b1;
        end
    end

    // Registered RAM read: the word for lane k appears the cycle after it was addressed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cap_valid <= 1'b0;
            r_cap_lane  <= '0;
            r_read_data <= '0;
        end else begin
            r_cap_valid <= (r_state == S_ACC) && !r_is_write;
            r_cap_lane  <= r_k;
            if (r_cap_valid) begin
                r_read_data[r_cap_lane] <= ram_rdata;
            end
        end
    end

    assign ReadData = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_mem_ctrl
// Purpose  : Directed self-checking bench for vector_mem_ctrl with a
//            registered-read 1024x18 RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vector_mem_ctrl;

    logic              clk;
    logic              rst;
    logic              MemReq;
    logic              MemWrite;
    logic [9:0]        A1, A2, A3;
    logic [2:0][17:0]  writeData;
    logic [2:0][17:0]  ReadData;
    logic              Stall;
    logic              Done;
    logic [9:0]        ram_addr;
    logic              ram_we;
    logic [17:0]       ram_wdata;
    logic [17:0]       ram_rdata;

    logic [17:0]       mem [1024];

    int                tests = 0;
    int                fails = 0;
    logic [9:0]        wa [8];
    logic [17:0]       wd [8];

    vector_mem_ctrl #(.ADDR_W(10), .DATA_W(18), .LANES(3)) dut (
        .CLK       (clk),
        .RST       (rst),
        .MemReq    (MemReq),
        .MemWrite  (MemWrite),
        .A1        (A1),
        .A2        (A2),
        .A3        (A3),
        .writeData (writeData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .Done      (Done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access: request for a single cycle, then garbage on the inputs until Done.
    task automatic access(input logic wr, input logic [9:0] a1, a2, a3,
                          input logic [17:0] d0, d1, d2,
                          output int stalls, output int done_at, output int nw,
                          output logic [53:0] rd);
        step();
        MemReq = 1'b1; MemWrite = wr; A1 = a1; A2 = a2; A3 = a3;
        writeData = {d2, d1, d0};
        stalls = 0; done_at = -1; nw = 0; rd = '0;
        @(negedge clk);
        if (Stall) stalls++;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 1) begin
                MemReq = 1'b0; MemWrite = ~wr; A1 = '0; A2 = '0; A3 = '0; writeData = '1;
            end
            @(negedge clk);
            if (Stall) stalls++;
            if (ram_we && nw < 8) begin
                wa[nw] = ram_addr; wd[nw] = ram_wdata; nw++;
            end
            if (Done) begin
                done_at = i; rd = ReadData;
                break;
            end
        end
    endtask

    initial begin
        int          stalls, done_at, nw;
        logic [53:0] rd;
        logic        seen;

        rst = 1'b1; MemReq = 1'b0; MemWrite = 1'b0;
        A1 = '0; A2 = '0; A3 = '0; writeData = '0;

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_readdata", ReadData, 54'h0);
            check("rst_stall", Stall, 1'b0);
            check("rst_done", Done, 1'b0);
            check("rst_we", ram_we, 1'b0);
        end
        step(); rst = 1'b0;
        @(negedge clk);
        check("idle_stall", Stall, 1'b0);

        // Write 5/6/7
        access(1'b1, 10'd5, 10'd6, 10'd7, 18'h11, 18'h22, 18'h33, stalls, done_at, nw, rd);
        check("wr_stalls", stalls, 4);
        check("wr_done_at", done_at, 4);
        check("wr_count", nw, 3);
        check("wr_a0", {wa[0], wd[0]}, {10'd5, 18'h11});
        check("wr_a1", {wa[1], wd[1]}, {10'd6, 18'h22});
        check("wr_a2", {wa[2], wd[2]}, {10'd7, 18'h33});
        check("wr_readdata_kept", rd, 54'h0);

        // Read back
        access(1'b0, 10'd5, 10'd6, 10'd7, 18'h0, 18'h0, 18'h0, stalls, done_at, nw, rd);
        check("rd_stalls", stalls, 5);
        check("rd_done_at", done_at, 5);
        check("rd_no_we", nw, 0);
        check("rd_data", rd, {18'h33, 18'h22, 18'h11});
        step(); @(negedge clk);
        check("rd_done_pulse", Done, 1'b0);
        check("rd_hold", ReadData, {18'h33, 18'h22, 18'h11});

        // Duplicate-address write then read
        access(1'b1, 10'd9, 10'd9, 10'd9, 18'h1, 18'h2, 18'h3, stalls, done_at, nw, rd);
        check("dup_wr_count", nw, 3);
        check("dup_wr_last", {wa[2], wd[2]}, {10'd9, 18'h3});
        access(1'b0, 10'd9, 10'd9, 10'd9, 18'h0, 18'h0, 18'h0, stalls, done_at, nw, rd);
        check("dup_rd_done_at", done_at, 5);
        check("dup_rd_data", rd, {18'h3, 18'h3, 18'h3});

        // Reset in the middle of a write
        step();
        MemReq = 1'b1; MemWrite = 1'b1; A1 = 10'd5; A2 = 10'd6; A3 = 10'd7;
        writeData = {18'hCC, 18'hBB, 18'hAA};
        @(negedge clk);
        check("mr_req_stall", Stall, 1'b1);
        step(); MemReq = 1'b0;
        @(negedge clk);
        check("mr_lane0", {ram_we, ram_addr, ram_wdata}, {1'b1, 10'd5, 18'hAA});
        step(); rst = 1'b1;
        @(negedge clk);
        check("mr_we_in_rst", ram_we, 1'b0);
        step(); rst = 1'b0;
        @(negedge clk);
        check("mr_idle", {Stall, Done, ram_we}, 3'b000);
        check("mr_readdata", ReadData, 54'h0);
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(); @(negedge clk);
            if (Done || ram_we || Stall) seen = 1'b1;
        end
        check("mr_quiet", seen, 1'b0);
        check("mr_mem5", mem[5], 18'hAA);
        check("mr_mem6", mem[6], 18'h22);
        check("mr_mem7", mem[7], 18'h33);

        // Back-to-back reads with MemReq held high
        step();
        MemReq = 1'b1; MemWrite = 1'b0; A1 = 10'd5; A2 = 10'd6; A3 = 10'd7;
        @(negedge clk);
        check("bb_t0_stall", Stall, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            step(); @(negedge clk);
            check("bb_busy_stall", Stall, 1'b1);
        end
        step(); @(negedge clk);
        check("bb_done1", {Done, Stall}, 2'b10);
        check("bb_data1", ReadData, {18'h33, 18'h22, 18'hAA});
        step(); A1 = 10'd9; A2 = 10'd9; A3 = 10'd9;
        @(negedge clk);
        check("bb_accept2", {Done, Stall}, 2'b01);
        check("bb_hold_a", ReadData, {18'h33, 18'h22, 18'hAA});
        step(); MemReq = 1'b0;
        @(negedge clk);
        check("bb_addr2", {ram_we, ram_addr}, {1'b0, 10'd9});
        check("bb_hold_b", ReadData, {18'h33, 18'h22, 18'hAA});
        step(); @(negedge clk);
        check("bb_hold_c", ReadData, {18'h33, 18'h22, 18'hAA});
        step(); @(negedge clk);
        check("bb_lane0", ReadData, {18'h33, 18'h22, 18'h3});
        step(); @(negedge clk);
        check("bb_lane1", ReadData, {18'h33, 18'h3, 18'h3});
        step(); @(negedge clk);
        check("bb_done2", {Done, Stall}, 2'b10);
        check("bb_data2", ReadData, {18'h3, 18'h3, 18'h3});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
